// File: rtl/rssi_sched_if.sv
// ADC handshake bundle: rssi_sched drives the master side, the ADC block the slave side.
interface rssi_sched_if;
  logic       adc_en;
  logic       adc_shdn;
  logic       adc_rdy;
  logic       adc_data_rdy;
  logic [7:0] adc_data;

  modport master (
    output adc_en,
    output adc_shdn,
    input  adc_rdy,
    input  adc_data_rdy,
    input  adc_data
  );

  modport slave (
    input  adc_en,
    input  adc_shdn,
    output adc_rdy,
    output adc_data_rdy,
    output adc_data
  );
endinterface

// File: rtl/rssi_sched.sv
// RSSI measurement scheduler: wakes the ADC, averages 2^AVG_LOG2 samples, puts it back to sleep.
// Define RSSI_SCHED_CCA_EN to enable the carrier-sense compare driving ch_busy_o.
//
// state | meaning
// INIT  | wait for ADC ready, then send the power-down command
// IDLE  | ADC powered down; wait for start or periodic timer
// WAKE  | power-up requested; wait for ADC ready
// CONV  | one-cycle conversion command
// WAIT  | wait for sample, accumulate, decide next conversion or finish
// SLEEP | publish average; send power-down command when ADC ready
module rssi_sched #(
  parameter int AVG_LOG2 = 2,
  parameter int TMO_CYC  = 63
) (
  input  logic         clk,
  input  logic         resetn,
  rssi_sched_if.master adc,
  input  logic         start_i,
  input  logic         periodic_en_i,
  input  logic [15:0]  period_i,
  input  logic [7:0]   threshold_i,
  output logic [7:0]   rssi_avg_o,
  output logic         rssi_valid_o,
  output logic         ch_busy_o,
  output logic         busy_o,
  output logic         err_o
);
  localparam int AW = 8 + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam int TW = $clog2(TMO_CYC + 2);
  localparam logic [CW-1:0] NSMP = CW'(1 << AVG_LOG2);
  localparam logic [TW-1:0] TMO  = TW'(TMO_CYC);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_WAKE, S_CONV, S_WAIT, S_SLEEP} state_e;

  state_e        state_q, state_d;
  logic [15:0]   per_q, per_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          smp_q, smp_d;
  logic          drdy_q;
  logic          en_q, en_d;
  logic          shdn_q, shdn_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic [7:0]    avg_q, avg_d;

  logic trig, drdy_rise, tmo_hit;

  assign trig      = start_i || (periodic_en_i && (per_q == '0));
  assign drdy_rise = adc.adc_data_rdy && !drdy_q;
  assign tmo_hit   = (tmo_q == TMO) &&
                     (state_q == S_INIT || state_q == S_WAKE ||
                      state_q == S_WAIT || state_q == S_SLEEP);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_INIT;
      per_q   <= '0;
      tmo_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      smp_q   <= 1'b0;
      drdy_q  <= 1'b0;
      en_q    <= 1'b0;
      shdn_q  <= 1'b1;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b1;
      avg_q   <= '0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      tmo_q   <= tmo_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      smp_q   <= smp_d;
      drdy_q  <= adc.adc_data_rdy;
      en_q    <= en_d;
      shdn_q  <= shdn_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      avg_q   <= avg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    smp_d   = smp_q;
    if (tmo_hit) begin
      state_d = S_INIT;
    end else begin
      case (state_q)
        S_INIT:  if (adc.adc_rdy) state_d = S_IDLE;
        S_IDLE: begin
          if (trig) begin
            state_d = S_WAKE;
            acc_d   = '0;
            cnt_d   = '0;
          end
        end
        S_WAKE:  if (adc.adc_rdy) state_d = S_CONV;
        S_CONV: begin
          state_d = S_WAIT;
          smp_d   = 1'b0;
        end
        S_WAIT: begin
          if (drdy_rise) begin
            acc_d = acc_q + AW'(adc.adc_data);
            cnt_d = cnt_q + CW'(1);
            smp_d = 1'b1;
          end
          // after a sample is in, the next conversion still has to wait for ready
          if (drdy_rise || smp_q) begin
            if (cnt_d == NSMP)    state_d = S_SLEEP;
            else if (adc.adc_rdy) state_d = S_CONV;
          end
        end
        S_SLEEP: if (adc.adc_rdy) state_d = S_IDLE;
        default: state_d = S_INIT;
      endcase
    end

    if (state_d != state_q || tmo_hit) tmo_d = '0;
    else if (tmo_q == TMO)             tmo_d = tmo_q;
    else                               tmo_d = tmo_q + TW'(1);

    if (state_d == S_IDLE && state_q != S_IDLE)  per_d = period_i;
    else if (state_q == S_IDLE && per_q != '0)   per_d = per_q - 16'd1;
    else                                         per_d = per_q;
  end

  always_comb begin
    en_d    = (state_d == S_CONV) ||
              (state_d == S_IDLE && (state_q == S_INIT || state_q == S_SLEEP));
    shdn_d  = (state_d == S_INIT) || (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    err_d   = tmo_hit;
    valid_d = (state_q == S_WAIT) && (state_d == S_SLEEP);
    avg_d   = valid_d ? acc_d[AW-1:AVG_LOG2] : avg_q;
  end

`ifdef RSSI_SCHED_CCA_EN
  logic ch_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      ch_q <= 1'b0;
    else if (valid_d) ch_q <= (avg_d >= threshold_i);
  end
  assign ch_busy_o = ch_q;
`else
  logic unused_thr;
  assign unused_thr = ^threshold_i;
  assign ch_busy_o  = 1'b0;
`endif

  assign adc.adc_en   = en_q;
  assign adc.adc_shdn = shdn_q;
  assign rssi_avg_o   = avg_q;
  assign rssi_valid_o = valid_q;
  assign busy_o       = busy_q;
  assign err_o        = err_q;
endmodule

// File: tb/tb_rssi_sched.sv
// Scoreboard bench for rssi_sched with a behavioural ADC model (power-up, wake, convert, shutdown).
module tb_rssi_sched;
  localparam int TMO_CYC  = 63;
  localparam int PWRUP    = 20;
  localparam int WAKE_LAT = 5;
  localparam int CONV_LAT = 4;
  localparam int SHDN_LAT = 2;
  localparam int OP_WAKE  = 1;
  localparam int OP_CONV  = 2;
  localparam int OP_SHDN  = 3;
`ifdef RSSI_SCHED_CCA_EN
  localparam bit CCA = 1'b1;
`else
  localparam bit CCA = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        start = 1'b0;
  logic        periodic_en = 1'b0;
  logic [15:0] period = '0;
  logic [7:0]  threshold = 8'd25;
  logic [7:0]  rssi_avg;
  logic        rssi_valid, ch_busy, busy, err;

  always #5 clk = ~clk;

  rssi_sched_if adc_if();

  rssi_sched #(.AVG_LOG2(2), .TMO_CYC(TMO_CYC)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .adc          (adc_if),
    .start_i      (start),
    .periodic_en_i(periodic_en),
    .period_i     (period),
    .threshold_i  (threshold),
    .rssi_avg_o   (rssi_avg),
    .rssi_valid_o (rssi_valid),
    .ch_busy_o    (ch_busy),
    .busy_o       (busy),
    .err_o        (err)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: ready drops immediately when woken from power-down
  logic       rdy_q = 1'b0, asleep_q = 1'b0, drdy_q = 1'b0;
  logic [7:0] data_q = '0;
  int         op = OP_WAKE;
  int         op_cnt = PWRUP;
  bit         mute = 1'b0;
  byte unsigned samples[$];

  assign adc_if.adc_rdy      = rdy_q & ~(asleep_q & ~adc_if.adc_shdn);
  assign adc_if.adc_data_rdy = drdy_q;
  assign adc_if.adc_data     = data_q;

  always @(posedge clk) begin
    if (op_cnt > 0) begin
      op_cnt <= op_cnt - 1;
      if (op_cnt == 1) begin
        rdy_q <= 1'b1;
        if (op == OP_CONV && !mute) begin
          drdy_q <= 1'b1;
          data_q <= (samples.size() > 0) ? samples.pop_front() : 8'd0;
        end
        if (op == OP_SHDN) asleep_q <= 1'b1;
      end
    end else if (asleep_q && !adc_if.adc_shdn) begin
      asleep_q <= 1'b0;
      rdy_q    <= 1'b0;
      op       <= OP_WAKE;
      op_cnt   <= WAKE_LAT;
    end else if (adc_if.adc_en && adc_if.adc_rdy) begin
      rdy_q  <= 1'b0;
      drdy_q <= 1'b0;
      op     <= adc_if.adc_shdn ? OP_SHDN : OP_CONV;
      op_cnt <= adc_if.adc_shdn ? SHDN_LAT : CONV_LAT;
    end
  end

  int en_cnt = 0, en_shdn_cnt = 0, valid_cnt = 0, err_cnt = 0, conv_cyc = 0, err_cyc = 0;
  always @(negedge clk) begin
    if (adc_if.adc_en) begin
      en_cnt <= en_cnt + 1;
      if (adc_if.adc_shdn) en_shdn_cnt <= en_shdn_cnt + 1;
      else                 conv_cyc <= cyc;
    end
    if (rssi_valid) valid_cnt <= valid_cnt + 1;
    if (err) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
  end

  typedef struct {
    logic [7:0] avg;
    logic       ch;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  initial begin
    forever begin
      @(negedge clk);
      if (rssi_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_valid rssi_avg=%0d required=no_pulse", rssi_avg);
        end else begin
          mon_e = exp_q.pop_front();
          if (rssi_avg !== mon_e.avg || ch_busy !== mon_e.ch) begin
            failures++;
            $display("FAIL rssi_result avg=%0d ch_busy=%b required avg=%0d ch_busy=%b",
                     rssi_avg, ch_busy, mon_e.avg, mon_e.ch);
          end
        end
      end
      if (adc_if.adc_en) begin
        checks++;
        if (adc_if.adc_rdy !== 1'b1) begin
          failures++;
          $display("FAIL adc_en_without_rdy adc_rdy=%b required=1", adc_if.adc_rdy);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic nstep();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic wait_busy(input logic val, input int max, input string name);
    int n = 0;
    while (busy !== val && n < max) begin
      nstep();
      n++;
    end
    if (busy !== val) begin
      checks++;
      failures++;
      $display("FAIL %s_wait busy=%b required=%b within %0d cycles", name, busy, val, max);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    nstep();
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_busy"},     32'(busy), 1);
    chk({pfx, "_shdn"},     32'(adc_if.adc_shdn), 1);
    chk({pfx, "_en"},       32'(adc_if.adc_en), 0);
    chk({pfx, "_avg"},      32'(rssi_avg), 0);
    chk({pfx, "_valid"},    32'(rssi_valid), 0);
    chk({pfx, "_ch_busy"},  32'(ch_busy), 0);
    chk({pfx, "_err"},      32'(err), 0);
  endtask

  typedef struct {
    byte unsigned s[4];
    int           avg;
  } vec_t;

  function automatic exp_t mk_exp(input int avg);
    exp_t e;
    e.avg = avg[7:0];
    e.ch  = CCA && (avg >= int'(threshold));
    return e;
  endfunction

  task automatic load_vec(input vec_t v);
    foreach (v.s[i]) samples.push_back(v.s[i]);
    exp_q.push_back(mk_exp(v.avg));
  endtask

  task automatic measure(input vec_t v, input string name);
    int be, bv;
    be = en_cnt;
    bv = valid_cnt;
    load_vec(v);
    pulse_start();
    wait_busy(1'b1, 20, name);
    wait_busy(1'b0, 600, name);
    chk({name, "_en_pulses"}, en_cnt - be, 5);
    chk({name, "_valid_pulses"}, valid_cnt - bv, 1);
  endtask

  vec_t vecs[6];
  vec_t pvec[3];
  vec_t last_vec;
  int   gap, be, bv, berr, n;

  initial begin
    vecs[0].s = '{8'd10, 8'd20, 8'd30, 8'd41};     vecs[0].avg = 25;
    vecs[1].s = '{8'd24, 8'd24, 8'd24, 8'd24};     vecs[1].avg = 24;
    vecs[2].s = '{8'd25, 8'd25, 8'd25, 8'd25};     vecs[2].avg = 25;
    vecs[3].s = '{8'd1, 8'd1, 8'd1, 8'd2};         vecs[3].avg = 1;
    vecs[4].s = '{8'd255, 8'd255, 8'd255, 8'd255}; vecs[4].avg = 255;
    vecs[5].s = '{8'd0, 8'd0, 8'd3, 8'd0};         vecs[5].avg = 0;
    pvec[0].s = '{8'd40, 8'd40, 8'd40, 8'd40};     pvec[0].avg = 40;
    pvec[1].s = '{8'd3, 8'd5, 8'd7, 8'd9};         pvec[1].avg = 6;
    pvec[2].s = '{8'd100, 8'd101, 8'd102, 8'd103}; pvec[2].avg = 101;
    last_vec.s = '{8'd8, 8'd8, 8'd8, 8'd8};        last_vec.avg = 8;

    resetn = 1'b0;
    repeat (3) nstep();
    check_reset_outputs("rst");
    resetn = 1'b1;

    wait_busy(1'b0, 200, "init");
    chk("init_en_count", en_cnt, 1);
    chk("init_en_shdn_count", en_shdn_cnt, 1);
    chk("init_first_en_after_pwrup", 32'(conv_cyc == 0 && cyc >= PWRUP), 1);

    foreach (vecs[i]) begin
      repeat (3) nstep();
      measure(vecs[i], $sformatf("vec%0d", i));
    end

    // periodic: first trigger immediate (counter loaded with 0), then spaced by period
    repeat (3) nstep();
    bv = valid_cnt;
    foreach (pvec[i]) load_vec(pvec[i]);
    period = 16'd100;
    periodic_en = 1'b1;
    wait_busy(1'b1, 20, "per_trig");
    pulse_start();
    wait_busy(1'b0, 600, "per_meas1");
    for (int k = 0; k < 2; k++) begin
      gap = 0;
      while (busy === 1'b0 && gap < 300) begin
        gap++;
        nstep();
      end
      // 100 decrements plus the trigger cycle itself
      chk($sformatf("per_gap%0d", k + 1), gap, 101);
      if (k == 1) periodic_en = 1'b0;
      wait_busy(1'b0, 600, "per_meas");
    end
    period = 16'd0;
    chk("per_valid_pulses", valid_cnt - bv, 3);

    // timeout in WAIT: ADC never presents data
    repeat (3) nstep();
    berr = err_cnt;
    mute = 1'b1;
    pulse_start();
    n = 0;
    while (err !== 1'b1 && n < 400) begin
      nstep();
      n++;
    end
    chk("tmo_err_seen", 32'(err), 1);
    chk("tmo_err_delay", err_cyc - conv_cyc, TMO_CYC + 2);
    chk("tmo_busy", 32'(busy), 1);
    chk("tmo_shdn", 32'(adc_if.adc_shdn), 1);
    chk("tmo_avg_hold", 32'(rssi_avg), 101);
    nstep();
    chk("tmo_err_one_cycle", 32'(err), 0);
    mute = 1'b0;
    wait_busy(1'b0, 200, "tmo_recover");
    chk("tmo_err_count", err_cnt - berr, 1);
    chk("tmo_avg_hold_after", 32'(rssi_avg), 101);

    // reset while in WAIT with two samples accumulated
    repeat (3) nstep();
    be = en_cnt;
    bv = valid_cnt;
    samples.push_back(8'd50);
    samples.push_back(8'd60);
    samples.push_back(8'd70);
    samples.push_back(8'd80);
    pulse_start();
    n = 0;
    while ((en_cnt - be) < 3 && n < 300) begin
      nstep();
      n++;
    end
    chk("rst2_reach_third_conv", en_cnt - be, 3);
    nstep();
    resetn = 1'b0;
    nstep();
    check_reset_outputs("rst2");
    nstep();
    resetn = 1'b1;
    wait_busy(1'b0, 200, "rst2_recover");
    repeat (5) nstep();
    chk("rst2_no_valid", valid_cnt - bv, 0);
    samples.delete();

    repeat (3) nstep();
    measure(last_vec, "post_rst");

    repeat (5) nstep();
    chk("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
